axi_full_s_mem: RTL and testbench

AXI4 full-protocol slave that terminates AXI_FULL_M_module transactions on an internal 64-bit-wide RAM, forming the memory side of the CPU's AXI bus. Independent read and write state machines serve one outstanding burst per direction, with full-throughput data beats, per-beat byte strobes, and SLVERR reporting. Simulation and FPGA bring-up use it as the instruction/data backing store.

---
 rtl/axi_pkg.sv | 23 ++
 rtl/axi_burst_addr_gen.sv | 31 +++
 rtl/axi_full_s_mem.sv | 231 +++++++++++++++++++++++
 tb/tb_axi_full_s_mem.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared burst/response encodings and FSM state types for the AXI memory slave
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// rtl/axi_burst_addr_gen.sv - per-beat next address, RAM word index and error decode
module axi_burst_addr_gen #(
    parameter int                ADDR_W = 32,
    parameter logic [ADDR_W-1:0] BASE   = '0,
    parameter int                DEPTH  = 1024,
    parameter int                IDX_W  = $clog2(DEPTH)
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [2:0]        size_i,
    input  logic [1:0]        burst_i,
    output logic [ADDR_W-1:0] next_addr_o,
    output logic [IDX_W-1:0]  word_o,
    output logic              err_o
);
    import axi_pkg::*;

    logic [ADDR_W-1:0] offset;
    logic              range_err;
    logic              cmd_err;

    // An address below BASE wraps the offset high, so it also lands in range_err.
    always_comb begin
        offset      = addr_i - BASE;
        range_err   = offset >= ADDR_W'(DEPTH * 8);
        cmd_err     = (size_i > 3'd3) || (burst_i == BURST_WRAP) || (burst_i == BURST_RSVD);
        err_o       = range_err || cmd_err;
        word_o      = offset[IDX_W+2:3];
        next_addr_o = (burst_i == BURST_INCR) ? addr_i + (ADDR_W'(1) << size_i) : addr_i;
    end

endmodule

// File: rtl/axi_full_s_mem.sv
// rtl/axi_full_s_mem.sv - AXI4 slave with independent read/write burst FSMs over a byte-writable RAM
module axi_full_s_mem #(
    parameter logic [31:0] C_S_TARGET_BASE_ADDR = 32'h00000000,
    parameter int          C_S_AXI_ID_WIDTH     = 4,
    parameter int          C_S_AXI_ADDR_WIDTH   = 32,
    parameter int          C_S_AXI_DATA_WIDTH   = 64,
    parameter int          C_MEM_DEPTH          = 1024
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic [2:0]                      S_AXI_AWSIZE,
    input  logic [1:0]                      S_AXI_AWBURST,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic [2:0]                      S_AXI_ARSIZE,
    input  logic [1:0]                      S_AXI_ARBURST,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);
    import axi_pkg::*;

    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int IDX_W = $clog2(C_MEM_DEPTH);

    function automatic logic [AW-1:0] align_addr(input logic [AW-1:0] a, input logic [2:0] s);
        return a & ~((AW'(1) << s) - AW'(1));
    endfunction

    logic [C_S_AXI_DATA_WIDTH-1:0] mem [C_MEM_DEPTH];

    w_state_t                      w_state_q;
    logic                          awready_q, wready_q, bvalid_q;
    logic [1:0]                    bresp_q;
    logic [C_S_AXI_ID_WIDTH-1:0]   bid_q;
    logic [AW-1:0]                 waddr_q;
    logic [7:0]                    wlen_q, wcnt_q;
    logic [2:0]                    wsize_q;
    logic [1:0]                    wburst_q;
    logic                          werr_q, werr_d;

    r_state_t                      r_state_q;
    logic                          arready_q, rvalid_q, rlast_q;
    logic [1:0]                    rresp_q;
    logic [C_S_AXI_ID_WIDTH-1:0]   rid_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
    logic [AW-1:0]                 raddr_q;
    logic [7:0]                    rlen_q, rcnt_q;
    logic [2:0]                    rsize_q;
    logic [1:0]                    rburst_q;

    logic [AW-1:0]    w_next_addr, r_gen_addr, r_next_addr;
    logic [IDX_W-1:0] w_word, r_word;
    logic             w_err, r_err, w_last_beat, w_mem_we;
    logic [2:0]       r_gen_size;
    logic [1:0]       r_gen_burst;

    axi_burst_addr_gen #(.ADDR_W(AW), .BASE(AW'(C_S_TARGET_BASE_ADDR)), .DEPTH(C_MEM_DEPTH)) u_w_gen (
        .addr_i(waddr_q), .size_i(wsize_q), .burst_i(wburst_q),
        .next_addr_o(w_next_addr), .word_o(w_word), .err_o(w_err)
    );

    // In idle the read generator looks at the incoming AR command so beat 0 loads on the handshake edge.
    always_comb begin
        r_gen_addr  = (r_state_q == R_IDLE) ? align_addr(S_AXI_ARADDR, S_AXI_ARSIZE) : raddr_q;
        r_gen_size  = (r_state_q == R_IDLE) ? S_AXI_ARSIZE  : rsize_q;
        r_gen_burst = (r_state_q == R_IDLE) ? S_AXI_ARBURST : rburst_q;
    end

    axi_burst_addr_gen #(.ADDR_W(AW), .BASE(AW'(C_S_TARGET_BASE_ADDR)), .DEPTH(C_MEM_DEPTH)) u_r_gen (
        .addr_i(r_gen_addr), .size_i(r_gen_size), .burst_i(r_gen_burst),
        .next_addr_o(r_next_addr), .word_o(r_word), .err_o(r_err)
    );

    always_comb begin
        w_last_beat = (wcnt_q == wlen_q);
        werr_d      = werr_q || w_err || (S_AXI_WLAST != w_last_beat);
        w_mem_we    = S_AXI_ARESETN && wready_q && S_AXI_WVALID && !w_err;
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (w_mem_we) begin
            for (int b = 0; b < C_S_AXI_DATA_WIDTH / 8; b++) begin
                if (S_AXI_WSTRB[b]) mem[w_word][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            bid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            werr_q    <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (awready_q && S_AXI_AWVALID) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        bid_q     <= S_AXI_AWID;
                        waddr_q   <= align_addr(S_AXI_AWADDR, S_AXI_AWSIZE);
                        wlen_q    <= S_AXI_AWLEN;
                        wsize_q   <= S_AXI_AWSIZE;
                        wburst_q  <= S_AXI_AWBURST;
                        wcnt_q    <= '0;
                        werr_q    <= 1'b0;
                        w_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (S_AXI_WVALID) begin
                        wcnt_q  <= wcnt_q + 8'd1;
                        waddr_q <= w_next_addr;
                        werr_q  <= werr_d;
                        if (w_last_beat) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            bresp_q   <= werr_d ? RESP_SLVERR : RESP_OKAY;
                            w_state_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rid_q     <= '0;
            rdata_q   <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (arready_q && S_AXI_ARVALID) begin
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rid_q     <= S_AXI_ARID;
                        rlen_q    <= S_AXI_ARLEN;
                        rsize_q   <= S_AXI_ARSIZE;
                        rburst_q  <= S_AXI_ARBURST;
                        rcnt_q    <= '0;
                        rlast_q   <= (S_AXI_ARLEN == 8'd0);
                        raddr_q   <= r_next_addr;
                        rdata_q   <= r_err ? '0 : mem[r_word];
                        rresp_q   <= r_err ? RESP_SLVERR : RESP_OKAY;
                        r_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            r_state_q <= R_IDLE;
                        end else begin
                            rcnt_q  <= rcnt_q + 8'd1;
                            rlast_q <= ((rcnt_q + 8'd1) == rlen_q);
                            raddr_q <= r_next_addr;
                            rdata_q <= r_err ? '0 : mem[r_word];
                            rresp_q <= r_err ? RESP_SLVERR : RESP_OKAY;
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_BID     = bid_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RID     = rid_q;
    assign S_AXI_RDATA   = rdata_q;

endmodule

// File: tb/tb_axi_full_s_mem.sv
// tb/tb_axi_full_s_mem.sv - directed self-checking bench for axi_full_s_mem
module tb_axi_full_s_mem;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  awid = '0, arid = '0, bid, rid;
    logic [31:0] awaddr = '0, araddr = '0;
    logic [7:0]  awlen = '0, arlen = '0;
    logic [2:0]  awsize = '0, arsize = '0;
    logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
    logic        awvalid = 1'b0, awready, wvalid = 1'b0, wready, wlast = 1'b0;
    logic        bvalid, bready = 1'b0, arvalid = 1'b0, arready;
    logic        rvalid, rready = 1'b0, rlast;
    logic [63:0] wdata = '0, rdata;
    logic [7:0]  wstrb = '0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] wbuf [16];
    logic [7:0]  sbuf [16];
    logic [63:0] rbuf [16];
    logic [1:0]  rresp_b [16];
    logic        rlast_b [16];
    logic [3:0]  rid_b [16];
    logic [1:0]  resp_o;
    logic [3:0]  bid_o;

    always #5 clk = ~clk;

    axi_full_s_mem dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(resetn),
        .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
        .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize),
        .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            output logic [1:0] resp, output logic [3:0] id_out);
        int t;
        @(negedge clk);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 50) begin @(negedge clk); t++; end
        check_eq("aw_ready_wait", 64'(awready), 64'd1);
        @(negedge clk);
        awvalid = 1'b0;
        check_eq("wready_after_aw", 64'(wready), 64'd1);
        for (int b = 0; b <= int'(len); b++) begin
            wdata = wbuf[b]; wstrb = sbuf[b]; wlast = (b == int'(len)); wvalid = 1'b1;
            t = 0;
            while (!wready && t < 50) begin @(negedge clk); t++; end
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        check_eq("bvalid_after_wlast", 64'(bvalid), 64'd1);
        bready = 1'b1;
        t = 0;
        while (!bvalid && t < 50) begin @(negedge clk); t++; end
        resp = bresp; id_out = bid;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit toggle);
        int t, b, cyc;
        bit hold_pending;
        logic [63:0] held;
        @(negedge clk);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 50) begin @(negedge clk); t++; end
        check_eq("ar_ready_wait", 64'(arready), 64'd1);
        @(negedge clk);
        arvalid = 1'b0;
        check_eq("rvalid_latency", 64'(rvalid), 64'd1);
        b = 0; cyc = 0; hold_pending = 1'b0; held = '0;
        while (b <= int'(len) && cyc < 200) begin
            if (hold_pending) check_eq("rdata_hold", rdata, held);
            hold_pending = 1'b0;
            rready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (rvalid && rready) begin
                rbuf[b] = rdata; rresp_b[b] = rresp; rlast_b[b] = rlast; rid_b[b] = rid;
                b++;
            end else if (rvalid) begin
                held = rdata; hold_pending = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        rready = 1'b0;
        check_eq("read_beats", 64'(b), 64'(int'(len) + 1));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_awready", 64'(awready), 64'd0);
        check_eq("rst_arready", 64'(arready), 64'd0);
        check_eq("rst_wready", 64'(wready), 64'd0);
        check_eq("rst_bvalid", 64'(bvalid), 64'd0);
        check_eq("rst_rvalid", 64'(rvalid), 64'd0);
        resetn = 1'b1;
        @(negedge clk);
        check_eq("post_rst_awready", 64'(awready), 64'd1);
        check_eq("post_rst_arready", 64'(arready), 64'd1);

        // single write then read
        wbuf[0] = 64'h1122334455667788; sbuf[0] = 8'hFF;
        do_write(4'd5, 32'h10, 8'd0, 3'd3, 2'b01, resp_o, bid_o);
        check_eq("single_bresp", 64'(resp_o), 64'd0);
        check_eq("single_bid", 64'(bid_o), 64'd5);
        do_read(4'd3, 32'h10, 8'd0, 3'd3, 2'b01, 1'b0);
        check_eq("single_rdata", rbuf[0], 64'h1122334455667788);
        check_eq("single_rlast", 64'(rlast_b[0]), 64'd1);
        check_eq("single_rresp", 64'(rresp_b[0]), 64'd0);
        check_eq("single_rid", 64'(rid_b[0]), 64'd3);

        // INCR burst, read back with RREADY stalls
        for (int i = 0; i < 4; i++) begin wbuf[i] = 64'hA0 + 64'(i); sbuf[i] = 8'hFF; end
        do_write(4'd1, 32'h40, 8'd3, 3'd3, 2'b01, resp_o, bid_o);
        check_eq("burst_bresp", 64'(resp_o), 64'd0);
        do_read(4'd2, 32'h40, 8'd3, 3'd3, 2'b01, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check_eq("burst_rdata", rbuf[i], 64'hA0 + 64'(i));
            check_eq("burst_rlast", 64'(rlast_b[i]), 64'(i == 3));
        end

        // FIXED size-2 traffic with partial strobe
        wbuf[0] = 64'h0; sbuf[0] = 8'hFF;
        do_write(4'd0, 32'h0, 8'd0, 3'd3, 2'b01, resp_o, bid_o);
        wbuf[0] = 64'hFFFFFFFF_FFFFFFFF; sbuf[0] = 8'h0F;
        do_write(4'd0, 32'h0, 8'd0, 3'd2, 2'b00, resp_o, bid_o);
        check_eq("strb_bresp", 64'(resp_o), 64'd0);
        for (int i = 0; i < 3; i++) begin
            do_read(4'(i), 32'h0, 8'd0, 3'd2, 2'b00, 1'b0);
            check_eq("fixed_rid", 64'(rid_b[0]), 64'(i));
            check_eq("strb_rdata", rbuf[0], 64'h00000000_FFFFFFFF);
        end

        // out of range and WRAP
        wbuf[0] = 64'hDEAD_BEEF; sbuf[0] = 8'hFF;
        do_write(4'd7, 32'h2000, 8'd0, 3'd3, 2'b01, resp_o, bid_o);
        check_eq("oor_bresp", 64'(resp_o), 64'd2);
        do_read(4'd0, 32'h0, 8'd0, 3'd3, 2'b01, 1'b0);
        check_eq("oor_no_alias", rbuf[0], 64'h00000000_FFFFFFFF);
        do_read(4'd0, 32'h2000, 8'd0, 3'd3, 2'b01, 1'b0);
        check_eq("oor_rresp", 64'(rresp_b[0]), 64'd2);
        check_eq("oor_rdata", rbuf[0], 64'd0);
        wbuf[0] = 64'h55; wbuf[1] = 64'h66; sbuf[0] = 8'hFF; sbuf[1] = 8'hFF;
        do_write(4'd1, 32'h80, 8'd1, 3'd3, 2'b10, resp_o, bid_o);
        check_eq("wrap_bresp", 64'(resp_o), 64'd2);
        do_read(4'd1, 32'h40, 8'd1, 3'd3, 2'b10, 1'b0);
        for (int i = 0; i < 2; i++) begin
            check_eq("wrap_rresp", 64'(rresp_b[i]), 64'd2);
            check_eq("wrap_rdata", rbuf[i], 64'd0);
        end

        // same-edge read and write to word 5: read-first
        wbuf[0] = 64'h1; sbuf[0] = 8'hFF;
        do_write(4'd2, 32'h28, 8'd0, 3'd3, 2'b01, resp_o, bid_o);
        @(negedge clk);
        awid = 4'd3; awaddr = 32'h28; awlen = 8'd0; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b1;
        check_eq("conc_awready", 64'(awready), 64'd1);
        @(negedge clk);
        awvalid = 1'b0;
        wdata = 64'h2; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1;
        arid = 4'd4; araddr = 32'h28; arlen = 8'd0; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
        check_eq("conc_wready", 64'(wready), 64'd1);
        check_eq("conc_arready", 64'(arready), 64'd1);
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
        check_eq("conc_rvalid", 64'(rvalid), 64'd1);
        check_eq("conc_read_first", rdata, 64'h1);
        check_eq("conc_bvalid", 64'(bvalid), 64'd1);
        check_eq("conc_bresp", 64'(bresp), 64'd0);
        rready = 1'b1; bready = 1'b1;
        @(negedge clk);
        rready = 1'b0; bready = 1'b0;
        do_read(4'd5, 32'h28, 8'd0, 3'd3, 2'b01, 1'b0);
        check_eq("conc_later_read", rbuf[0], 64'h2);

        // reset in the middle of a len-7 read
        @(negedge clk);
        arid = 4'd6; araddr = 32'h40; arlen = 8'd7; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
        check_eq("mid_arready", 64'(arready), 64'd1);
        @(negedge clk);
        arvalid = 1'b0; rready = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("mid_rvalid_beat2", 64'(rvalid), 64'd1);
        check_eq("mid_rdata_beat2", rdata, 64'hA2);
        resetn = 1'b0; rready = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_rvalid", 64'(rvalid), 64'd0);
        check_eq("mid_rst_arready", 64'(arready), 64'd0);
        resetn = 1'b1;
        @(negedge clk);
        check_eq("mid_rel_arready", 64'(arready), 64'd1);
        do_read(4'd9, 32'h10, 8'd0, 3'd3, 2'b01, 1'b0);
        check_eq("mid_new_read", rbuf[0], 64'h1122334455667788);
        check_eq("mid_new_rid", 64'(rid_b[0]), 64'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
